register_file_sb: RTL and testbench

//  Parametrised MIPS general-purpose register file with per-byte write merge and a load scoreboard.

---
 rtl/register_file_sb.sv | 106 ++++++++++
 tb/tb_register_file_sb.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_sb.sv
// MIPS GPR file with per-byte write merge and a load scoreboard (pending bits + count).
// Define WB_BYPASS_EN to forward the writeback value to same-cycle reads.
module register_file_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = 2,
    parameter int V0_IDX   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/8-1:0]        wr_be,
    input  logic                       pend_set,
    input  logic [ADDR_W-1:0]          pend_addr,
    output logic [ADDR_W:0]            pend_count,
    output logic [DATA_W-1:0]          register_v0
);

    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_REGS-1:0]             pending;
    logic [NUM_REGS-1:0]             pend_nxt;
    logic                            wr_ok;
    logic                            set_ok;
    logic                            inc;
    logic                            dec;

    // Index 0 and indices past the last register are inert everywhere.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a != '0) && ({1'b0, a} < LIM);
    endfunction

    function automatic logic [DATA_W-1:0] merge(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [NB-1:0]     be
    );
        logic [DATA_W-1:0] r;
        r = old_v;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) r[k*8 +: 8] = new_v[k*8 +: 8];
        end
        return r;
    endfunction

    assign wr_ok  = !reset && wr_en && in_range(wr_addr);
    assign set_ok = !reset && pend_set && in_range(pend_addr);

    // Set is applied after clear so a newer load on the same register wins.
    always_comb begin
        pend_nxt = pending;
        if (wr_ok)  pend_nxt[wr_addr]   = 1'b0;
        if (set_ok) pend_nxt[pend_addr] = 1'b1;
    end

    assign inc = set_ok && !pending[pend_addr];
    assign dec = wr_ok && pending[wr_addr] &&
                 !(set_ok && (pend_addr == wr_addr));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs       <= '0;
            pending    <= '0;
            pend_count <= '0;
        end else begin
            if (wr_ok) regs[wr_addr] <= merge(regs[wr_addr], wr_data, wr_be);
            pending <= pend_nxt;
            if (inc && !dec)      pend_count <= pend_count + ONE;
            else if (dec && !inc) pend_count <= pend_count - ONE;
        end
    end

    assign register_v0 = regs[V0_IDX];

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              ok;
        logic [DATA_W-1:0] q;
        logic              b;

        assign a  = rd_addr[g*ADDR_W +: ADDR_W];
        assign ok = in_range(a);
        assign q  = ok ? regs[a] : '0;
        assign b  = ok ? pending[a] : 1'b0;

`ifdef WB_BYPASS_EN
        logic hit;
        assign hit = ok && wr_ok && (wr_addr == a);
        assign rd_data[g*DATA_W +: DATA_W] = hit ? merge(q, wr_data, wr_be) : q;
        assign rd_busy[g] = hit ? (set_ok && (pend_addr == a)) : b;
`else
        assign rd_data[g*DATA_W +: DATA_W] = q;
        assign rd_busy[g] = b;
`endif
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench for register_file_sb: driver pushes model predictions, negedge monitor checks.
// Honours WB_BYPASS_EN in the reference model.
module tb_register_file_sb;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int RD = 2;
    localparam int V0 = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [RD*AW-1:0] rd_addr;
    logic [RD*DW-1:0] rd_data;
    logic [RD-1:0]    rd_busy;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic [DW/8-1:0]  wr_be;
    logic             pend_set;
    logic [AW-1:0]    pend_addr;
    logic [AW:0]      pend_count;
    logic [DW-1:0]    register_v0;

    always #5 clk = ~clk;

    register_file_sb #(
        .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(RD), .V0_IDX(V0)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .pend_set(pend_set), .pend_addr(pend_addr),
        .pend_count(pend_count), .register_v0(register_v0)
    );

    typedef struct {
        int               id;
        logic [RD*DW-1:0] rd;
        logic [RD-1:0]    busy;
        logic [AW:0]      cnt;
        logic [DW-1:0]    v0;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;
    int          seq   = 0;
    logic [31:0] m_reg [NR];
    bit          m_pend[NR];

    function automatic logic [31:0] mrg(input logic [31:0] o,
                                        input logic [31:0] n,
                                        input logic [3:0]  be);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++) if (be[k]) r[k*8 +: 8] = n[k*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_reg[r]  = '0;
            m_pend[r] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (wr_en && wr_addr != 0) begin
            m_reg[wr_addr]  = mrg(m_reg[wr_addr], wr_data, wr_be);
            m_pend[wr_addr] = 1'b0;
        end
        if (pend_set && pend_addr != 0) m_pend[pend_addr] = 1'b1;
    endtask

    task automatic push_exp();
        exp_t e;
        int   c;
        e.id   = seq;
        e.rd   = '0;
        e.busy = '0;
        e.cnt  = '0;
        e.v0   = '0;
        seq++;
        if (!reset) begin
            for (int p = 0; p < RD; p++) begin
                logic [4:0]  a;
                logic [31:0] d;
                logic        b;
                a = rd_addr[p*AW +: AW];
                d = (a == 0) ? 32'h0 : m_reg[a];
                b = (a == 0) ? 1'b0 : m_pend[a];
`ifdef WB_BYPASS_EN
                if (a != 0 && wr_en && wr_addr == a) begin
                    d = mrg(m_reg[a], wr_data, wr_be);
                    b = pend_set && (pend_addr == a);
                end
`endif
                e.rd[p*DW +: DW] = d;
                e.busy[p]        = b;
            end
            c = 0;
            for (int r = 0; r < NR; r++) c += int'(m_pend[r]);
            e.cnt = (AW + 1)'(c);
            e.v0  = m_reg[V0];
        end
        sbq.push_back(e);
    endtask

    task automatic chk(input string nm, input int id,
                       input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s id=%0d got=%h want=%h", nm, id, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("rd_data0", e.id, 64'(rd_data[31:0]),  64'(e.rd[31:0]));
            chk("rd_data1", e.id, 64'(rd_data[63:32]), 64'(e.rd[63:32]));
            chk("rd_busy",  e.id, 64'(rd_busy),        64'(e.busy));
            chk("pend_cnt", e.id, 64'(pend_count),     64'(e.cnt));
            chk("reg_v0",   e.id, 64'(register_v0),    64'(e.v0));
        end
    end

    task automatic step(input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic ps, input logic [4:0] pa,
                        input logic [4:0] a0, input logic [4:0] a1);
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        wr_be     = be;
        pend_set  = ps;
        pend_addr = pa;
        rd_addr   = {a1, a0};
        push_exp();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        wr_be     = '0;
        pend_set  = 1'b0;
        pend_addr = '0;
        rd_addr   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        step(0, 0, 0, 0, 0, 0, 5, 2);
        step(1, 0, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        step(1, 7, 32'h1122_3344, 4'hF, 0, 0, 7, 0);
        step(1, 7, 32'hAABB_CCDD, 4'b1100, 0, 0, 7, 7);
        step(1, 7, 32'hAABB_CCDD, 4'b0011, 0, 0, 7, 7);
        step(1, 7, 32'h0000_0000, 4'b0000, 0, 0, 7, 7);
        step(0, 0, 0, 0, 0, 0, 7, 0);

        step(0, 0, 0, 0, 1, 3, 3, 4);
        step(0, 0, 0, 0, 1, 4, 3, 4);
        step(1, 3, 32'h33, 4'hF, 1, 9, 3, 9);
        step(1, 4, 32'h44, 4'hF, 1, 4, 4, 3);
        step(0, 0, 0, 0, 0, 0, 4, 9);

        step(1, 8, 32'h1, 4'hF, 0, 0, 8, 0);
        step(0, 0, 0, 0, 1, 8, 8, 0);
        step(1, 8, 32'h55, 4'hF, 0, 0, 8, 8);
        step(1, 8, 32'h66, 4'hF, 1, 8, 8, 0);
        step(0, 0, 0, 0, 0, 0, 8, 8);

        step(1, 2, 32'hCAFE_F00D, 4'hF, 0, 0, 2, 0);
        step(1, 2, 32'h0000_0012, 4'b0001, 0, 0, 2, 2);
        step(0, 0, 0, 0, 0, 0, 2, 0);

        for (int r = 1; r < NR; r++) step(0, 0, 0, 0, 1, 5'(r), 5'(r), 5'(r - 1));
        step(0, 0, 0, 0, 1, 17, 17, 31);
        step(0, 0, 0, 0, 0, 0, 0, 31);
        for (int r = 1; r < NR; r++) step(1, 5'(r), $urandom, 4'hF, 0, 0, 5'(r), 0);

        step(1, 5, 32'hDEAD_BEEF, 4'hF, 1, 6, 5, 6);
        step(1, 2, 32'h77, 4'hF, 0, 0, 5, 6);
        wr_en     = 1'b1;
        wr_addr   = 5;
        wr_data   = 32'h1234_5678;
        wr_be     = 4'hF;
        pend_set  = 1'b1;
        pend_addr = 9;
        rd_addr   = {5'd6, 5'd5};
        #1;
        reset = 1'b1;
        model_reset();
        push_exp();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(0, 0, 0, 0, 0, 0, 5, 6);
        step(0, 0, 0, 0, 0, 0, 2, 9);

        repeat (400) begin
            logic [4:0] wa;
            logic [4:0] pa;
            logic [4:0] a0;
            logic [4:0] a1;
            wa = 5'($urandom_range(0, 31));
            pa = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            a0 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 2) == 0) ? pa : 5'($urandom_range(0, 31));
            step(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom),
                 ($urandom_range(0, 2) == 0), pa, a0, a1);
        end

        repeat (3) @(posedge clk);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
